// File: rtl/irda_status_register.sv
// ---------------------------------------------------------------------------
// irda_status_register
//
// Read-side Wishbone responder for the IrDA control/status address space.
// Collects single-cycle TX/RX event pulses into sticky status bits, masks them
// with the interrupt-enable register onto int_o, keeps a saturating count of
// good received frames and returns registered read data with a one-cycle ack.
//
// Ports
//   clk         system clock, all state on the rising edge
//   wb_rst_n    asynchronous active-low reset
//   wb_addr_i   register address
//   wb_dat_i    write data (only the IER address is stored here)
//   wb_we_i     1 = write, 0 = read
//   wb_stb_i    strobe
//   wb_cyc_i    bus cycle valid
//   wb_dat_o    registered read data, held until the next read
//   wb_ack_o    single-cycle transfer acknowledge, one cycle after request
//   master_i    master control bits [7:1] for read-back
//   event_i     single-cycle event pulses, one per status bit
//   rx_frame_i  single-cycle pulse per good received frame
//   int_o       registered interrupt request, active high
// ---------------------------------------------------------------------------
module irda_status_register #(
   parameter logic [3:0] ADDR_MASTER = 4'h0,
   parameter logic [3:0] ADDR_STATUS = 4'h2,
   parameter logic [3:0] ADDR_IER    = 4'h3,
   parameter logic [3:0] ADDR_FCNT   = 4'h4
) (
   input  logic       clk,
   input  logic       wb_rst_n,
   input  logic [3:0] wb_addr_i,
   input  logic [7:0] wb_dat_i,
   input  logic       wb_we_i,
   input  logic       wb_stb_i,
   input  logic       wb_cyc_i,
   output logic [7:0] wb_dat_o,
   output logic       wb_ack_o,
   input  logic [7:1] master_i,
   input  logic [7:0] event_i,
   input  logic       rx_frame_i,
   output logic       int_o
);

   logic [7:0] status_q, status_d;
   logic [7:0] ier_q,    ier_d;
   logic [7:0] fcnt_q,   fcnt_d;
   logic [7:0] dat_q,    dat_d;
   logic       ack_q,    ack_d;
   logic       int_q,    int_d;

   logic       req;
   logic       rd_req;
   logic       wr_req;
   logic       status_clr;
   logic       fcnt_clr;
   logic [7:0] rd_data;
   logic [7:0] fcnt_base;

   always_comb begin
      // Blocking on ack_q makes a held strobe see ack, gap, ack.
      req    = wb_cyc_i & wb_stb_i & ~ack_q;
      rd_req = req & ~wb_we_i;
      wr_req = req & wb_we_i;

      rd_data = 8'h00;
      case (wb_addr_i)
         ADDR_MASTER: rd_data = {master_i, 1'b0};
         ADDR_STATUS: rd_data = status_q;
         ADDR_IER:    rd_data = ier_q;
         ADDR_FCNT:   rd_data = fcnt_q;
         default:     rd_data = 8'h00;
      endcase

      status_clr = rd_req & (wb_addr_i == ADDR_STATUS);
      fcnt_clr   = rd_req & (wb_addr_i == ADDR_FCNT);

      // The read returns all of status_q, so clearing all of it clears
      // exactly the returned bits; OR-ing events afterwards lets set win.
      status_d = (status_clr ? 8'h00 : status_q) | event_i;

      ier_d = (wr_req & (wb_addr_i == ADDR_IER)) ? wb_dat_i : ier_q;

      // A frame arriving on the clearing read counts from zero.
      fcnt_base = fcnt_clr ? 8'h00 : fcnt_q;
      fcnt_d    = fcnt_base;
      if (rx_frame_i && (fcnt_base != 8'hFF)) begin
         fcnt_d = fcnt_base + 8'd1;
      end

      dat_d = rd_req ? rd_data : dat_q;
      ack_d = req;
      int_d = |(status_d & ier_d);
   end

   always_ff @(posedge clk or negedge wb_rst_n) begin
      if (!wb_rst_n) begin
         status_q <= 8'h00;
         ier_q    <= 8'h00;
         fcnt_q   <= 8'h00;
         dat_q    <= 8'h00;
         ack_q    <= 1'b0;
         int_q    <= 1'b0;
      end else begin
         status_q <= status_d;
         ier_q    <= ier_d;
         fcnt_q   <= fcnt_d;
         dat_q    <= dat_d;
         ack_q    <= ack_d;
         int_q    <= int_d;
      end
   end

   assign wb_dat_o = dat_q;
   assign wb_ack_o = ack_q;
   assign int_o    = int_q;

endmodule

// File: tb/tb_irda_status_register.sv
// ---------------------------------------------------------------------------
// tb_irda_status_register
//
// Bench for irda_status_register. A driver applies one cycle of inputs at a
// time on the falling edge and advances a transaction-level reference model;
// the expected ack/int_o of every cycle and the expected read data of every
// acked transfer are queued. A monitor, forked from the same process, pops
// and compares after each rising edge.
// ---------------------------------------------------------------------------
module tb_irda_status_register;

   logic       clk = 1'b0;
   logic       wb_rst_n;
   logic [3:0] wb_addr_i;
   logic [7:0] wb_dat_i;
   logic       wb_we_i;
   logic       wb_stb_i;
   logic       wb_cyc_i;
   logic [7:0] wb_dat_o;
   logic       wb_ack_o;
   logic [7:1] master_i;
   logic [7:0] event_i;
   logic       rx_frame_i;
   logic       int_o;

   always #5 clk = ~clk;

   irda_status_register dut (
      .clk        (clk),
      .wb_rst_n   (wb_rst_n),
      .wb_addr_i  (wb_addr_i),
      .wb_dat_i   (wb_dat_i),
      .wb_we_i    (wb_we_i),
      .wb_stb_i   (wb_stb_i),
      .wb_cyc_i   (wb_cyc_i),
      .wb_dat_o   (wb_dat_o),
      .wb_ack_o   (wb_ack_o),
      .master_i   (master_i),
      .event_i    (event_i),
      .rx_frame_i (rx_frame_i),
      .int_o      (int_o)
   );

   typedef struct packed {
      logic ack;
      logic irq;
   } cyc_exp_t;

   cyc_exp_t   cq[$];
   logic [7:0] dq[$];
   int         tests = 0;
   int         fails = 0;
   bit         mon_en = 1'b0;

   // reference model state
   logic [7:0] m_status;
   logic [7:0] m_ier;
   logic [7:0] m_dat;
   int         m_fcnt;
   bit         m_ack;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_status = 8'h00;
      m_ier    = 8'h00;
      m_dat    = 8'h00;
      m_fcnt   = 0;
      m_ack    = 1'b0;
   endtask

   // One bus cycle: drive inputs, predict the outcome of the next rising edge.
   task automatic step(input logic cyc, input logic stb, input logic we,
                       input logic [3:0] addr, input logic [7:0] wd,
                       input logic [7:0] ev, input logic rxf);
      logic     req;
      cyc_exp_t e;
      wb_cyc_i   = cyc;
      wb_stb_i   = stb;
      wb_we_i    = we;
      wb_addr_i  = addr;
      wb_dat_i   = wd;
      event_i    = ev;
      rx_frame_i = rxf;

      req = cyc && stb && !m_ack;
      if (req && !we) begin
         case (addr)
            4'h0:    m_dat = {master_i, 1'b0};
            4'h2:    m_dat = m_status;
            4'h3:    m_dat = m_ier;
            4'h4:    m_dat = 8'(m_fcnt);
            default: m_dat = 8'h00;
         endcase
         if (addr == 4'h2) m_status = 8'h00;
         if (addr == 4'h4) m_fcnt = 0;
      end
      if (req && we && addr == 4'h3) m_ier = wd;
      m_status = m_status | ev;
      if (rxf) m_fcnt = (m_fcnt + 1 > 255) ? 255 : m_fcnt + 1;
      m_ack = req;

      e.ack = req;
      e.irq = |(m_status & m_ier);
      cq.push_back(e);
      if (req) dq.push_back(m_dat);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic rd(input logic [3:0] addr, input logic [7:0] ev = 8'h00, input logic rxf = 1'b0);
      step(1'b1, 1'b1, 1'b0, addr, 8'h00, ev, rxf);
      idle(1);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [7:0] d);
      step(1'b1, 1'b1, 1'b1, addr, d, 8'h00, 1'b0);
      idle(1);
   endtask

   task automatic monitor_loop();
      cyc_exp_t   e;
      logic [7:0] d;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en && wb_rst_n) begin
            if (cq.size() == 0) begin
               chk("cycle_queue_underflow", 8'h01, 8'h00);
            end else begin
               e = cq.pop_front();
               chk("ack", 8'(wb_ack_o), 8'(e.ack));
               chk("int_o", 8'(int_o), 8'(e.irq));
            end
            if (wb_ack_o) begin
               if (dq.size() == 0) begin
                  chk("data_queue_underflow", 8'h01, 8'h00);
               end else begin
                  d = dq.pop_front();
                  chk("wb_dat_o", wb_dat_o, d);
               end
            end
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] a_set[4];
      a_set = '{4'h0, 4'h2, 4'h3, 4'h4};

      wb_rst_n   = 1'b0;
      wb_cyc_i   = 1'b0;
      wb_stb_i   = 1'b0;
      wb_we_i    = 1'b0;
      wb_addr_i  = 4'h0;
      wb_dat_i   = 8'h00;
      event_i    = 8'h00;
      rx_frame_i = 1'b0;
      master_i   = 7'b1010011;
      model_reset();

      fork
         monitor_loop();
      join_none

      repeat (2) @(negedge clk);
      wb_rst_n = 1'b1;
      mon_en   = 1'b1;

      // Prelude: interrupt high and status non-zero before the reset test.
      wr(4'h3, 8'hFF);
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h01, 1'b0);
      idle(1);

      // Reset asserted while an ack is high.
      mon_en    = 1'b0;
      wb_cyc_i  = 1'b1;
      wb_stb_i  = 1'b1;
      wb_we_i   = 1'b0;
      wb_addr_i = 4'h0;
      @(posedge clk);
      #1;
      chk("pre_reset_ack", 8'(wb_ack_o), 8'h01);
      chk("pre_reset_int", 8'(int_o), 8'h01);
      chk("pre_reset_dat", wb_dat_o, 8'hA6);
      wb_rst_n = 1'b0;
      #1;
      chk("reset_ack", 8'(wb_ack_o), 8'h00);
      chk("reset_int", 8'(int_o), 8'h00);
      chk("reset_dat", wb_dat_o, 8'h00);
      @(posedge clk);
      #1;
      chk("reset_held_ack", 8'(wb_ack_o), 8'h00);
      @(negedge clk);
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
      wb_rst_n = 1'b1;
      model_reset();
      mon_en = 1'b1;

      rd(4'h2);
      rd(4'h3);
      rd(4'h4);

      // Master read-back, unmapped address, held strobe.
      rd(4'h0);
      rd(4'hF);
      repeat (4) step(1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0);
      idle(1);

      // Sticky status with clear-on-read, set wins on the clearing edge.
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h05, 1'b0);
      rd(4'h2);
      rd(4'h2);
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h04, 1'b0);
      rd(4'h2, 8'h02);
      rd(4'h2);

      // Interrupt masking.
      wr(4'h3, 8'h04);
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h01, 1'b0);
      idle(1);
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h04, 1'b0);
      idle(1);
      rd(4'h2);
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h04, 1'b0);
      idle(1);
      wr(4'h3, 8'h00);
      rd(4'h2);

      // Frame counter saturation and coincident clear.
      for (int k = 0; k < 300; k++) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      rd(4'h4);
      rd(4'h4);
      repeat (3) step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b1);
      rd(4'h4, 8'h00, 1'b1);
      rd(4'h4);

      // Writes: status not writable, IER round trip, read data held.
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h10, 1'b0);
      wr(4'h2, 8'h5A);
      rd(4'h2);
      wr(4'h3, 8'h5A);
      rd(4'h3);
      wr(4'h0, 8'hFF);

      // Strobe without cycle is ignored.
      step(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h20, 1'b0);
      step(1'b0, 1'b1, 1'b0, 4'h2, 8'h00, 8'h00, 1'b0);
      step(1'b0, 1'b1, 1'b1, 4'h3, 8'hFF, 8'h00, 1'b0);
      idle(1);
      rd(4'h2);
      rd(4'h3);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         logic [3:0] a;
         logic [7:0] ev;
         a  = ($urandom_range(0, 7) < 6) ? a_set[$urandom_range(0, 3)] : 4'($urandom);
         ev = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'h00;
         if ($urandom_range(0, 15) == 0) master_i = 7'($urandom);
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 3) == 0, a, 8'($urandom), ev,
              $urandom_range(0, 2) == 0);
      end

      idle(3);
      chk("queues_drained", 8'(cq.size() + dq.size()), 8'h00);
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/irda_status_register.md
Name: irda_status_register

Overview:
Wishbone read-side responder for the IrDA core's control/status address space. It collects single-cycle event pulses from the TX/RX engines into sticky status bits and gates them through an interrupt-enable mask onto int_o. It keeps a saturating received-frame counter and returns registered read data with a one-cycle-latency ack, including read-back of the master control bits. It sits beside the master control register on the same wb_addr_i/wb_dat_i bus.

Parameters:
ADDR_MASTER, 4'h0, address of master register read-back
ADDR_STATUS, 4'h2, address of sticky status register (clear-on-read)
ADDR_IER, 4'h3, address of interrupt-enable register (R/W)
ADDR_FCNT, 4'h4, address of received-frame counter (clear-on-read)

Ports:
clk  input  1  system clock, all state on rising edge
wb_rst_n  input  1  asynchronous, active-low reset
wb_addr_i  input  4  register address
wb_dat_i  input  8  write data
wb_we_i  input  1  1 = write, 0 = read
wb_stb_i  input  1  strobe
wb_cyc_i  input  1  bus cycle valid
wb_dat_o  output  8  registered read data
wb_ack_o  output  1  transfer acknowledge
master_i  input  7  master control bits [7:1] for read-back
event_i  input  8  single-cycle event pulses, one per status bit
rx_frame_i  input  1  single-cycle pulse per good received frame
int_o  output  1  registered interrupt request, active high

Behaviour:
- Reset (wb_rst_n low, async): status=0, ier=0, fcnt=0, wb_dat_o=0, wb_ack_o=0, int_o=0. Reset asserted mid-transfer drops ack immediately. No ack is issued for that request.
- Request: req = wb_cyc_i & wb_stb_i & ~wb_ack_o.
- Every req is acked exactly one cycle later. wb_ack_o is a single-cycle pulse.
- A stb held high gets ack on alternate cycles (ack, gap, ack). Each ack is one transfer.
- Read (req & ~wb_we_i): wb_dat_o is loaded on the same edge that raises ack. It holds its value until the next read.
  - ADDR_MASTER: {master_i[7:1], 1'b0}.
  - ADDR_STATUS: status.
  - ADDR_IER: ier.
  - ADDR_FCNT: fcnt.
  - Any other address: 8'h00, still acked.
- Write (req & wb_we_i): only ADDR_IER is stored here (ier <= wb_dat_i on the req edge). Writes to other addresses are acked with no effect. wb_dat_o is unchanged on writes.
- Status: status[n] sets on event_i[n]=1 and stays set until cleared.
  - A status read clears exactly the bits returned in that read's wb_dat_o.
  - If event_i[n] pulses on the clearing edge, status[n] stays 1 (set wins). The following read returns it.
- Frame counter: 8-bit fcnt increments on rx_frame_i and saturates at 8'hFF.
  - A read of ADDR_FCNT returns the current value and clears fcnt.
  - If rx_frame_i coincides with the clearing read, fcnt becomes 1.
- int_o <= |(status_next & ier_next). It is registered, so it rises one cycle after the setting event pulse, and falls the cycle after the clearing read or the IER write that masks it.
- wb_cyc_i low with wb_stb_i high is ignored (no ack, no side effects).

Test Plan:
- Reset/idle: assert wb_rst_n=0 mid-read with ack pending -> wb_ack_o, int_o, wb_dat_o = 0 at once; after release, reading ADDR_STATUS/ADDR_IER/ADDR_FCNT returns 8'h00 each.
- Master read-back: master_i=7'b1010011, read ADDR_MASTER -> ack exactly 1 cycle after stb, wb_dat_o=8'hA6; stb held 4 cycles -> exactly 2 ack pulses; read addr 4'hF -> 8'h00, acked.
- Sticky and clear-on-read: pulse event_i=8'h05, read STATUS -> 8'h05; read again -> 8'h00. Pulse event_i[1] on the clearing edge of a read returning 8'h04 -> next read returns 8'h02.
- Interrupt mask: write IER=8'h04, pulse event_i[0] -> int_o stays 0; pulse event_i[2] -> int_o=1 the following cycle; read STATUS -> int_o=0 the cycle after ack; write IER=8'h00 with a pending masked bit -> int_o=0.
- Frame counter: 300 rx_frame_i pulses -> FCNT read 8'hFF, next read 8'h00; rx_frame_i coincident with the clearing read -> next read 8'h01.
- Writes: write 8'h5A to ADDR_STATUS -> acked, status unchanged; write ADDR_IER=8'h5A then read ADDR_IER -> 8'h5A; wb_dat_o unchanged across writes.
